// File: rtl/alu_pkg.sv
// Shared encodings for the execute unit: ALUop classes, R-type funct codes,
// the mul/div iteration state enum and the decoded operation enum.
// The signed mul/div extension is enabled with ALU_SIGNED_MULDIV_EN.
package alu_pkg;

   localparam logic [2:0] ALUOP_ADD   = 3'b000;
   localparam logic [2:0] ALUOP_SUB   = 3'b001;
   localparam logic [2:0] ALUOP_RTYPE = 3'b010;
   localparam logic [2:0] ALUOP_AND   = 3'b011;
   localparam logic [2:0] ALUOP_SLT   = 3'b100;
   localparam logic [2:0] ALUOP_OR    = 3'b101;
   localparam logic [2:0] ALUOP_LUI   = 3'b110;
   localparam logic [2:0] ALUOP_ILL   = 3'b111;

   localparam logic [5:0] FN_SLL   = 6'b000000;
   localparam logic [5:0] FN_SRL   = 6'b000010;
   localparam logic [5:0] FN_MFHI  = 6'b010000;
   localparam logic [5:0] FN_MFLO  = 6'b010010;
   localparam logic [5:0] FN_MULT  = 6'b011000;
   localparam logic [5:0] FN_MULTU = 6'b011001;
   localparam logic [5:0] FN_DIV   = 6'b011010;
   localparam logic [5:0] FN_DIVU  = 6'b011011;
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_NOR   = 6'b100111;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam logic [5:0] FN_SLTU  = 6'b101011;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV
`ifdef ALU_SIGNED_MULDIV_EN
      , ST_FIX
`endif
   } md_state_t;

   typedef enum logic [4:0] {
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_SLT, OP_SLTU,
      OP_SLL, OP_SRL, OP_LUI, OP_MFHI, OP_MFLO,
      OP_MULTU, OP_DIVU, OP_MULT, OP_DIV, OP_ILL
   } alu_op_t;

   function automatic logic is_muldiv(input alu_op_t op);
      return (op == OP_MULTU) || (op == OP_DIVU) || (op == OP_MULT) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply/divide engine owning HI/LO. One bit per cycle:
// shift-add multiply and restoring divide. HI/LO double as the working
// registers, which is safe because nothing can read them while busy.
// With ALU_SIGNED_MULDIV_EN the engine also handles signed operands by
// iterating on magnitudes and fixing signs in one extra cycle.
//
// state   | meaning
// ST_IDLE | waiting for start, HI/LO hold last result
// ST_MUL  | shift-add step, counter counting down to 0
// ST_DIV  | restoring-divide step, counter counting down to 0
// ST_FIX  | (signed build) apply result signs, then finish
module alu_muldiv_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_div,
`ifdef ALU_SIGNED_MULDIV_EN
   input  logic             i_signed,
`endif
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_busy,
   output logic             o_fin,
   output logic [WIDTH-1:0] o_lo_fin,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   md_state_t        state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] opnd;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_sh;
   logic [WIDTH:0]   div_diff;
   logic             div_ok;
   logic [WIDTH-1:0] step_hi;
   logic [WIDTH-1:0] step_lo;
   logic             last;

`ifdef ALU_SIGNED_MULDIV_EN
   logic             fix_en;
   logic             was_div;
   logic             neg_q;
   logic             neg_r;
   logic [WIDTH-1:0] fix_hi;
   logic [WIDTH-1:0] fix_lo;
   logic [2*WIDTH-1:0] prod_neg;
   logic             use_mag;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic [WIDTH-1:0] ld_a;
   logic [WIDTH-1:0] ld_b;
`endif

   // One iteration of whichever operation is running
   always_comb begin
      mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
      div_sh   = {hi, lo[WIDTH-1]};
      div_diff = div_sh - {1'b0, opnd};
      div_ok   = ~div_diff[WIDTH];
      if (state == ST_DIV) begin
         step_hi = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
         step_lo = {lo[WIDTH-2:0], div_ok};
      end else begin
         step_hi = mul_sum[WIDTH:1];
         step_lo = {mul_sum[0], lo[WIDTH-1:1]};
      end
      last = ((state == ST_MUL) || (state == ST_DIV)) && (cnt == CNT_W'(1));
   end

`ifdef ALU_SIGNED_MULDIV_EN
   // Operand magnitudes on entry and sign fix-up of the final result;
   // a zero divisor runs unsigned on the raw operands
   always_comb begin
      mag_a    = i_a[WIDTH-1] ? -i_a : i_a;
      mag_b    = i_b[WIDTH-1] ? -i_b : i_b;
      use_mag  = i_signed && !(i_div && (i_b == '0));
      ld_a     = use_mag ? mag_a : i_a;
      ld_b     = use_mag ? mag_b : i_b;
      prod_neg = -{hi, lo};
      fix_hi   = hi;
      fix_lo   = lo;
      if (was_div) begin
         if (neg_q) fix_lo = -lo;
         if (neg_r) fix_hi = -hi;
      end else if (neg_q) begin
         {fix_hi, fix_lo} = prod_neg;
      end
   end

   assign o_fin    = (last && !fix_en) || (state == ST_FIX);
   assign o_lo_fin = (state == ST_FIX) ? fix_lo : step_lo;
`else
   assign o_fin    = last;
   assign o_lo_fin = step_lo;
`endif

   assign o_busy = (state != ST_IDLE);
   assign o_hi   = hi;
   assign o_lo   = lo;

   // Iteration FSM: load on start, step per cycle, finish at counter 0
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         opnd  <= '0;
         hi    <= '0;
         lo    <= '0;
`ifdef ALU_SIGNED_MULDIV_EN
         fix_en  <= 1'b0;
         was_div <= 1'b0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  cnt   <= CNT_W'(WIDTH);
                  hi    <= '0;
                  state <= i_div ? ST_DIV : ST_MUL;
`ifdef ALU_SIGNED_MULDIV_EN
                  lo      <= i_div ? ld_a : ld_b;
                  opnd    <= i_div ? ld_b : ld_a;
                  fix_en  <= i_signed;
                  was_div <= i_div;
                  neg_q   <= use_mag && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
                  neg_r   <= use_mag && i_div && i_a[WIDTH-1];
`else
                  lo    <= i_div ? i_a : i_b;
                  opnd  <= i_div ? i_b : i_a;
`endif
               end
            end
            ST_MUL, ST_DIV: begin
               hi  <= step_hi;
               lo  <= step_lo;
               cnt <= cnt - CNT_W'(1);
               if (last) begin
`ifdef ALU_SIGNED_MULDIV_EN
                  state <= fix_en ? ST_FIX : ST_IDLE;
`else
                  state <= ST_IDLE;
`endif
               end
            end
`ifdef ALU_SIGNED_MULDIV_EN
            ST_FIX: begin
               hi    <= fix_hi;
               lo    <= fix_lo;
               state <= ST_IDLE;
            end
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/alu_exec_unit.sv
// Sequential execute unit: ALUop/funct decode, single-cycle ALU with
// registered result/zero/done/illegal, and the iterative mul/div engine.
// Define ALU_SIGNED_MULDIV_EN to add signed mult/div.
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [2:0]       i_ALUop,
   input  logic [5:0]       i_funct,
   input  logic [4:0]       i_shamt,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_result,
   output logic             o_zero,
   output logic             o_done,
   output logic             o_illegal,
   output logic             o_busy
);

   localparam int SH_W = CNT_W - 1;

   alu_op_t          op;
   logic [WIDTH-1:0] alu_res;
   logic [SH_W-1:0]  sh_amt;
   logic             accept;
   logic             md_start;
   logic             md_div;
   logic             md_busy;
   logic             md_fin;
   logic [WIDTH-1:0] md_lo_fin;
   logic [WIDTH-1:0] md_hi;
   logic [WIDTH-1:0] md_lo;

   assign sh_amt   = SH_W'(i_shamt);
   assign o_ready  = ~md_busy;
   assign o_busy   = md_busy;
   assign accept   = i_valid && o_ready;
   assign md_start = accept && is_muldiv(op);
   assign md_div   = (op == OP_DIVU) || (op == OP_DIV);

   // Decode ALUop class and R-type funct into one operation
   always_comb begin
      op = OP_ILL;
      case (i_ALUop)
         ALUOP_ADD: op = OP_ADD;
         ALUOP_SUB: op = OP_SUB;
         ALUOP_AND: op = OP_AND;
         ALUOP_SLT: op = OP_SLT;
         ALUOP_OR:  op = OP_OR;
         ALUOP_LUI: op = OP_LUI;
         ALUOP_RTYPE: begin
            case (i_funct)
               FN_ADD:   op = OP_ADD;
               FN_SUB:   op = OP_SUB;
               FN_AND:   op = OP_AND;
               FN_OR:    op = OP_OR;
               FN_NOR:   op = OP_NOR;
               FN_SLT:   op = OP_SLT;
               FN_SLTU:  op = OP_SLTU;
               FN_SLL:   op = OP_SLL;
               FN_SRL:   op = OP_SRL;
               FN_MFHI:  op = OP_MFHI;
               FN_MFLO:  op = OP_MFLO;
               FN_MULTU: op = OP_MULTU;
               FN_DIVU:  op = OP_DIVU;
`ifdef ALU_SIGNED_MULDIV_EN
               FN_MULT:  op = OP_MULT;
               FN_DIV:   op = OP_DIV;
`endif
               default:  op = OP_ILL;
            endcase
         end
         default: op = OP_ILL;
      endcase
   end

   // Single-cycle ALU; illegal and mul/div ops produce zero here
   always_comb begin
      alu_res = '0;
      case (op)
         OP_ADD:  alu_res = i_a + i_b;
         OP_SUB:  alu_res = i_a - i_b;
         OP_AND:  alu_res = i_a & i_b;
         OP_OR:   alu_res = i_a | i_b;
         OP_NOR:  alu_res = ~(i_a | i_b);
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
         OP_SLL:  alu_res = i_b << sh_amt;
         OP_SRL:  alu_res = i_b >> sh_amt;
         OP_LUI:  alu_res = i_b << 16;
         OP_MFHI: alu_res = md_hi;
         OP_MFLO: alu_res = md_lo;
         default: alu_res = '0;
      endcase
   end

   alu_muldiv_iter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_muldiv (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_start  (md_start),
      .i_div    (md_div),
`ifdef ALU_SIGNED_MULDIV_EN
      .i_signed ((op == OP_MULT) || (op == OP_DIV)),
`endif
      .i_a      (i_a),
      .i_b      (i_b),
      .o_busy   (md_busy),
      .o_fin    (md_fin),
      .o_lo_fin (md_lo_fin),
      .o_hi     (md_hi),
      .o_lo     (md_lo)
   );

   // Output registers: result/zero hold between ops, done/illegal pulse
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_result  <= '0;
         o_zero    <= 1'b1;
         o_done    <= 1'b0;
         o_illegal <= 1'b0;
      end else begin
         o_done    <= 1'b0;
         o_illegal <= 1'b0;
         if (md_fin) begin
            o_result <= md_lo_fin;
            o_zero   <= (md_lo_fin == '0);
            o_done   <= 1'b1;
         end else if (accept && !is_muldiv(op)) begin
            o_result  <= alu_res;
            o_zero    <= (alu_res == '0);
            o_done    <= 1'b1;
            o_illegal <= (op == OP_ILL);
         end
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit (WIDTH=32); expected values are
// hand-computed constants. Covers ALU_SIGNED_MULDIV_EN when defined.
module tb_alu_exec_unit;

   localparam int W = 32;

   logic         i_clk = 1'b0;
   logic         i_rst;
   logic         i_valid;
   logic         o_ready;
   logic [2:0]   i_ALUop;
   logic [5:0]   i_funct;
   logic [4:0]   i_shamt;
   logic [W-1:0] i_a;
   logic [W-1:0] i_b;
   logic [W-1:0] o_result;
   logic         o_zero;
   logic         o_done;
   logic         o_illegal;
   logic         o_busy;

   int n_cmp = 0;
   int n_err = 0;

   alu_exec_unit #(.WIDTH(W)) dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_valid   (i_valid),
      .o_ready   (o_ready),
      .i_ALUop   (i_ALUop),
      .i_funct   (i_funct),
      .i_shamt   (i_shamt),
      .i_a       (i_a),
      .i_b       (i_b),
      .o_result  (o_result),
      .o_zero    (o_zero),
      .o_done    (o_done),
      .o_illegal (o_illegal),
      .o_busy    (o_busy)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; issues one op and checks it finishes next cycle
   task automatic run_single(input string tag, input logic [2:0] aluop, input logic [5:0] fn,
                             input logic [4:0] sh, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] exp, input logic exp_ill);
      i_ALUop = aluop;
      i_funct = fn;
      i_shamt = sh;
      i_a     = a;
      i_b     = b;
      i_valid = 1'b1;
      @(negedge i_clk);
      i_valid = 1'b0;
      check({tag, "_done"}, 64'(o_done), 64'd1);
      check(tag, 64'(o_result), 64'(exp));
      check({tag, "_zero"}, 64'(o_zero), 64'(exp == '0));
      check({tag, "_ill"}, 64'(o_illegal), 64'(exp_ill));
   endtask

   // Called at a negedge; issues a mul/div, measures latency and busy cycles.
   // With poke set, an add is offered mid-operation and must be ignored.
   task automatic run_md(input string tag, input logic [5:0] fn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_lo,
                         input int exp_lat, input bit poke);
      int lat;
      int busy_n;
      lat    = 0;
      busy_n = 0;
      i_ALUop = 3'b010;
      i_funct = fn;
      i_shamt = 5'd0;
      i_a     = a;
      i_b     = b;
      i_valid = 1'b1;
      while (lat < 200) begin
         @(negedge i_clk);
         lat++;
         if (lat == 1) i_valid = 1'b0;
         if (o_busy) busy_n++;
         if (o_done) break;
         if (poke && lat == 5) begin
            i_ALUop = 3'b000;
            i_a     = 32'd1;
            i_b     = 32'd1;
            i_valid = 1'b1;
         end
         if (poke && lat == 6) i_valid = 1'b0;
      end
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check({tag, "_busy"}, 64'(busy_n), 64'(exp_lat - 1));
      check({tag, "_lo"}, 64'(o_result), 64'(exp_lo));
      check({tag, "_ill"}, 64'(o_illegal), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int dones;
      i_rst   = 1'b1;
      i_valid = 1'b0;
      i_ALUop = 3'b000;
      i_funct = 6'd0;
      i_shamt = 5'd0;
      i_a     = '0;
      i_b     = '0;
      repeat (3) @(negedge i_clk);
      i_rst = 1'b0;
      check("rst_result",  64'(o_result),  64'd0);
      check("rst_zero",    64'(o_zero),    64'd1);
      check("rst_done",    64'(o_done),    64'd0);
      check("rst_illegal", 64'(o_illegal), 64'd0);
      check("rst_busy",    64'(o_busy),    64'd0);
      check("rst_ready",   64'(o_ready),   64'd1);

      run_single("add_r",   3'b010, 6'b100000, 5'd0,  32'd5,          32'd7,          32'd12,         1'b0);
      run_single("sub_eq",  3'b001, 6'b000000, 5'd0,  32'h0000_1234,  32'h0000_1234,  32'd0,          1'b0);
      run_single("slt",     3'b010, 6'b101010, 5'd0,  32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0);
      run_single("sltu",    3'b010, 6'b101011, 5'd0,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0);
      run_single("add_wrap",3'b000, 6'b000000, 5'd0,  32'hFFFF_FFFF,  32'd2,          32'd1,          1'b0);
      run_single("sub_r",   3'b010, 6'b100010, 5'd0,  32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0);
      run_single("and",     3'b011, 6'b000000, 5'd0,  32'hF0F0_1234,  32'h0FF0_FFFF,  32'h00F0_1234,  1'b0);
      run_single("or",      3'b101, 6'b000000, 5'd0,  32'hF000_0000,  32'h0000_000F,  32'hF000_000F,  1'b0);
      run_single("nor",     3'b010, 6'b100111, 5'd0,  32'h0F0F_0F0F,  32'h00FF_00FF,  32'hF000_F000,  1'b0);
      run_single("slt_opc", 3'b100, 6'b000000, 5'd0,  32'd7,          32'hFFFF_FFF0,  32'd0,          1'b0);
      run_single("lui",     3'b110, 6'b000000, 5'd0,  32'd0,          32'h0000_ABCD,  32'hABCD_0000,  1'b0);
      run_single("sll",     3'b010, 6'b000000, 5'd4,  32'd0,          32'h8000_0001,  32'h0000_0010,  1'b0);
      run_single("srl",     3'b010, 6'b000010, 5'd31, 32'd0,          32'h8000_0000,  32'd1,          1'b0);

      run_md("multu", 6'b011001, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, W + 1, 1'b0);
      run_single("mfhi_b2b", 3'b010, 6'b010000, 5'd0, 32'd0, 32'd0, 32'd1,         1'b0);
      run_single("mflo_mul", 3'b010, 6'b010010, 5'd0, 32'd0, 32'd0, 32'hFFFF_FFFE, 1'b0);

      run_md("divu", 6'b011011, 32'd100, 32'd7, 32'd14, W + 1, 1'b1);
      run_single("mfhi_div", 3'b010, 6'b010000, 5'd0, 32'd0, 32'd0, 32'd2, 1'b0);

      run_md("divu_z", 6'b011011, 32'd9, 32'd0, 32'hFFFF_FFFF, W + 1, 1'b0);
      run_single("mfhi_dz", 3'b010, 6'b010000, 5'd0, 32'd0, 32'd0, 32'd9, 1'b0);

      run_single("ill_fn",  3'b010, 6'b111111, 5'd0, 32'd5, 32'd7, 32'd0, 1'b1);
      run_single("mfhi_ill",3'b010, 6'b010000, 5'd0, 32'd0, 32'd0, 32'd9, 1'b0);
      run_single("ill_op",  3'b111, 6'b100000, 5'd0, 32'd5, 32'd7, 32'd0, 1'b1);

`ifdef ALU_SIGNED_MULDIV_EN
      run_md("mult", 6'b011000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, W + 2, 1'b0);
      run_single("mfhi_mult", 3'b010, 6'b010000, 5'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0);
      run_md("div", 6'b011010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, W + 2, 1'b0);
      run_single("mfhi_sdiv", 3'b010, 6'b010000, 5'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0);
`else
      run_single("mult_ill", 3'b010, 6'b011000, 5'd0, 32'd3, 32'd5, 32'd0, 1'b1);
      run_single("div_ill",  3'b010, 6'b011010, 5'd0, 32'd3, 32'd5, 32'd0, 1'b1);
`endif

      // Reset during a multiply aborts it and clears HI/LO
      run_single("pre_rst", 3'b000, 6'b000000, 5'd0, 32'd40, 32'd2, 32'd42, 1'b0);
      i_ALUop = 3'b010;
      i_funct = 6'b011001;
      i_a     = 32'd1234;
      i_b     = 32'd5678;
      i_valid = 1'b1;
      @(negedge i_clk);
      i_valid = 1'b0;
      repeat (9) @(negedge i_clk);
      check("mid_busy", 64'(o_busy), 64'd1);
      i_rst = 1'b1;
      @(negedge i_clk);
      i_rst = 1'b0;
      check("arst_busy",   64'(o_busy),   64'd0);
      check("arst_ready",  64'(o_ready),  64'd1);
      check("arst_done",   64'(o_done),   64'd0);
      check("arst_result", 64'(o_result), 64'd0);
      check("arst_zero",   64'(o_zero),   64'd1);
      dones = 0;
      repeat (40) begin
         @(negedge i_clk);
         if (o_done) dones++;
      end
      check("arst_no_done", 64'(dones), 64'd0);
      run_single("arst_mfhi", 3'b010, 6'b010000, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);
      run_single("arst_mflo", 3'b010, 6'b010010, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);

      @(negedge i_clk);
      check("idle_done", 64'(o_done), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised successor to the combinational ALU-control decode of the multicycle CPU.
- Merges ALUop/funct decode, a WIDTH-bit ALU, and an iterative multiply/divide engine with HI/LO registers into one sequential execute unit.
- Sits between the register-file read stage and the ALUOut register; the main control FSM waits on o_done.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 4 and even.
- CNT_W, $clog2(WIDTH)+1, width of the iteration counter.

Ports:
- i_clk, input, 1, system clock; all state changes on the rising edge.
- i_rst, input, 1, synchronous, active-high reset.
- i_valid, input, 1, operation request; sampled only when o_ready=1.
- o_ready, output, 1, unit idle and able to accept i_valid.
- i_ALUop, input, 3, main-control op class.
- i_funct, input, 6, R-type funct field.
- i_shamt, input, 5, shift amount, used by sll/srl.
- i_a, input, WIDTH, operand A (rs).
- i_b, input, WIDTH, operand B (rt or immediate).
- o_result, output, WIDTH, registered result.
- o_zero, output, 1, registered (o_result == 0).
- o_done, output, 1, one-cycle pulse; o_result/HI/LO valid this cycle.
- o_illegal, output, 1, pulses with o_done for an undecoded funct.
- o_busy, output, 1, multiply/divide in progress.

Behaviour:
- Reset:
  - Values: o_result=0, o_zero=1, o_done=0, o_illegal=0, o_busy=0, o_ready=1, HI=0, LO=0, state=IDLE.
  - Reset in any state aborts the operation; no o_done is issued.
- Decode by i_ALUop:
  - 000: add.
  - 001: sub.
  - 011: and.
  - 100: slt (signed).
  - 101: or.
  - 110: lui (i_b << 16).
  - 111: illegal.
  - 010: R-type, decoded by i_funct:
    - 100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor, 101010 slt (signed), 101011 sltu.
    - 000000 sll (i_b << i_shamt; a NOP is sll 0).
    - 000010 srl.
    - 010000 mfhi, 010010 mflo.
    - 011001 multu, 011011 divu.
    - Any other funct is illegal.
- Arithmetic: all add/sub are modulo 2^WIDTH and no overflow trap; shifts use shamt[CNT_W-2:0] only.
- FSM states: IDLE, MUL, DIV.
- IDLE:
  - Accept when i_valid & o_ready.
  - Single-cycle op or illegal: latch result; o_done (plus o_illegal if applicable) in the next cycle. Latency 1.
  - Illegal: o_result=0, HI/LO unchanged.
  - multu goes to MUL, divu goes to DIV. Operands are latched, counter=WIDTH, o_busy=1, o_ready=0.
- MUL: shift-add, one bit per cycle.
- DIV: restoring division, one bit per cycle.
- Completion:
  - MUL/DIV decrement the counter each cycle.
  - When the counter reaches 0, HI/LO are written on that edge, o_done pulses, o_busy drops, and the state returns to IDLE.
  - Accept at cycle N gives o_done at cycle N+WIDTH+1.
- Mul/div results:
  - multu: {HI,LO} = A*B, 2·WIDTH bits.
  - divu: LO=quotient, HI=remainder.
  - Divide by zero runs the full WIDTH cycles and yields LO = all ones, HI = i_a; o_illegal stays low.
- For mul/div, o_result = LO at o_done.
- o_result holds its value between operations.
- i_valid while o_busy is ignored, with no queuing.
- mfhi/mflo issued in the cycle of o_done read the updated HI/LO.
- Accept back-to-back: a new i_valid is accepted in the same cycle as the previous o_done.

Optional Feature:
- Macro ALU_SIGNED_MULDIV_EN.
- Defined:
  - Adds funct 011000 mult and 011010 div.
  - Operands are converted to magnitudes before iterating; signs are fixed up in one extra cycle, so latency is WIDTH+2.
  - Quotient sign = sign(A) xor sign(B); remainder sign = sign(A).
  - Divide by zero gives the same result as divu on the raw operands.
- Undefined: 011000 and 011010 are illegal.

Decomposition:
- Shared package alu_pkg holds:
  - ALUop encodings.
  - funct codes.
  - FSM state enum.
  - ALU operation enum produced by decode.
- Natural sub-module: alu_muldiv_iter, the MUL/DIV datapath with counter and HI/LO.
  - Interface: start/done handshake.
  - The top keeps decode, the single-cycle ALU and the output registers.

Test Plan:
- ALUop=010, funct=100000, A=5, B=7 → next cycle o_done=1, o_result=12, o_zero=0.
- ALUop=001, A=B=0x1234 → o_result=0, o_zero=1.
- ALUop=010, funct=101010, A=0xFFFFFFFF, B=1 → o_result=1; with sltu (101011) → o_result=0.
- multu, A=0xFFFFFFFF, B=2 → o_busy for 32 cycles; o_done at N+33 with HI=1, LO=0xFFFFFFFE. Then mfhi → 1.
- divu, A=100, B=7 → LO=14, HI=2. divu, A=9, B=0 → LO=0xFFFFFFFF, HI=9. An i_valid sent mid-divide is ignored.
- Assert i_rst at cycle 10 of a multu → o_busy=0, o_ready=1, HI=LO=0, no o_done. A funct of 111111 → o_illegal and o_done together, o_result=0.
